// File: rtl/wb_stage_pipe_buffer.sv
// wb_stage_pipe_buffer: DEPTH-entry elastic MEM->WB pipeline buffer with valid/ready handshake and flush.
// Define WBB_FWD_EN to add the register forwarding port (fwd_rs/fwd_hit/fwd_data).
module wb_stage_pipe_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [REG_W-1:0]           in_rd,
    input  logic                       in_link,
    input  logic                       in_wb_en,
    input  logic [FLAG_W-1:0]          in_flags,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [REG_W-1:0]           out_rd,
    output logic                       out_link,
    output logic                       out_wb_en,
    output logic [FLAG_W-1:0]          out_flags,
    output logic [$clog2(DEPTH+1)-1:0] occ
`ifdef WBB_FWD_EN
    ,
    input  logic [REG_W-1:0]           fwd_rs,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [REG_W-1:0]  rd_q    [DEPTH];
    logic              link_q  [DEPTH];
    logic              wb_q    [DEPTH];
    logic [FLAG_W-1:0] flags_q [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic              push, pop;
    assign in_ready  = occ != OW'(DEPTH);
    assign out_valid = occ != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            occ    <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + OW'(push) - OW'(pop);
        end
    end
    // Slot payload needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr]  <= in_data;
            rd_q[wr_ptr]    <= in_rd;
            link_q[wr_ptr]  <= in_link;
            wb_q[wr_ptr]    <= in_wb_en;
            flags_q[wr_ptr] <= in_flags;
        end
    end
    assign out_data  = out_valid ? data_q[rd_ptr]  : '0;
    assign out_rd    = out_valid ? rd_q[rd_ptr]    : '0;
    assign out_link  = out_valid ? link_q[rd_ptr]  : 1'b0;
    assign out_wb_en = out_valid ? wb_q[rd_ptr]    : 1'b0;
    assign out_flags = out_valid ? flags_q[rd_ptr] : '0;
`ifdef WBB_FWD_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(occ) && wb_q[rd_ptr + AW'(i)] && rd_q[rd_ptr + AW'(i)] == fwd_rs) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[rd_ptr + AW'(i)];
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_stage_pipe_buffer.sv
// tb_wb_stage_pipe_buffer: queue-model scoreboard plus directed vectors for wb_stage_pipe_buffer.
module tb_wb_stage_pipe_buffer;
    localparam int DEPTH = 2;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  rd;
        logic        link;
        logic        wb;
        logic [3:0]  fl;
    } ent_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_data = '0;
    logic [3:0]  in_rd = '0;
    logic        in_link = 1'b0, in_wb_en = 1'b0;
    logic [3:0]  in_flags = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_rd;
    logic        out_link, out_wb_en;
    logic [3:0]  out_flags;
    logic [1:0]  occ;
`ifdef WBB_FWD_EN
    logic [3:0]  fwd_rs = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif
    int n_cmp = 0, n_err = 0;
    ent_t q[$];

    wb_stage_pipe_buffer #(.DATA_W(32), .REG_W(4), .FLAG_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
        .in_link(in_link), .in_wb_en(in_wb_en), .in_flags(in_flags), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_link(out_link), .out_wb_en(out_wb_en), .out_flags(out_flags), .occ(occ)
`ifdef WBB_FWD_EN
        , .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: an ordered queue of accepted entries.
    always @(negedge reset) q.delete();
    always @(posedge clk) begin
        if (reset) begin
            if (flush) q.delete();
            else begin
                automatic bit do_push = in_valid && q.size() != DEPTH;
                automatic bit do_pop  = out_ready && q.size() != 0;
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{in_data, in_rd, in_link, in_wb_en, in_flags});
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            automatic ent_t h = q.size() != 0 ? q[0] : '0;
            chk("m_occ", 64'(occ), 64'(q.size()));
            chk("m_in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
            chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("m_out_data", 64'(out_data), 64'(h.d));
            chk("m_out_rd", 64'(out_rd), 64'(h.rd));
            chk("m_out_link", 64'(out_link), 64'(h.link));
            chk("m_out_wb_en", 64'(out_wb_en), 64'(h.wb));
            chk("m_out_flags", 64'(out_flags), 64'(h.fl));
`ifdef WBB_FWD_EN
            begin
                automatic logic        hit = 1'b0;
                automatic logic [31:0] fd = '0;
                foreach (q[k]) if (q[k].wb && q[k].rd == fwd_rs) begin hit = 1'b1; fd = q[k].d; end
                chk("m_fwd_hit", 64'(fwd_hit), 64'(hit));
                chk("m_fwd_data", 64'(fwd_data), 64'(fd));
            end
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] rd,
                         input logic wb, input logic [3:0] fl);
        in_valid = v; in_data = d; in_rd = rd; in_wb_en = wb; in_flags = fl; in_link = d[0];
    endtask

    initial begin
        #1;
        chk("rst_occ", 64'(occ), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        step(); step();
        reset = 1'b1;
        drive(1, 32'hDEADBEEF, 4'd5, 1, 4'h8);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", 64'(out_valid), 1);
        chk("single_data", 64'(out_data), 64'hDEADBEEF);
        chk("single_rd", 64'(out_rd), 5);
        chk("single_flags", 64'(out_flags), 8);
        chk("single_wb", 64'(out_wb_en), 1);
        step();
        chk("single_empty", 64'(out_valid), 0);
        chk("single_empty_data", 64'(out_data), 0);
        out_ready = 1'b0;
        drive(1, 32'h11, 4'd1, 1, 4'h1);
        step();
        drive(1, 32'h22, 4'd2, 1, 4'h2);
        step();
        drive(1, 32'h33, 4'd3, 1, 4'h3);
        chk("fill_in_ready", 64'(in_ready), 0);
        chk("fill_occ", 64'(occ), 2);
        step();
        chk("fill_hold_occ", 64'(occ), 2);
        chk("fill_hold_head", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        step();
        chk("rel_head1", 64'(out_data), 64'h22);
        chk("rel_in_ready", 64'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("rel_head2", 64'(out_data), 64'h33);
        chk("rel_occ2", 64'(occ), 1);
        step();
        chk("rel_empty", 64'(out_valid), 0);
        out_ready = 1'b0;
        drive(1, 32'h40, 4'd4, 0, 4'h0);
        step();
        drive(1, 32'h44, 4'd4, 1, 4'h4);
        out_ready = 1'b1;
        step();
        chk("conc_occ", 64'(occ), 1);
        chk("conc_head", 64'(out_data), 64'h44);
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h50 + 32'(i), 4'(i), 1, 4'(i));
            step();
            chk("wrap_head", 64'(out_data), 64'(32'h50 + 32'(i)));
            chk("wrap_occ", 64'(occ), 1);
        end
        in_valid = 1'b0;
        step();
        chk("wrap_drain", 64'(occ), 0);
        out_ready = 1'b0;
        drive(1, 32'h61, 4'd6, 1, 4'h6);
        step();
        drive(1, 32'h62, 4'd6, 1, 4'h6);
        step();
        chk("flush_pre_occ", 64'(occ), 2);
        drive(1, 32'h63, 4'd6, 1, 4'h6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 64'(occ), 0);
        chk("flush_valid", 64'(out_valid), 0);
        step();
        chk("flush_discard", 64'(occ), 0);
`ifdef WBB_FWD_EN
        drive(1, 32'hA, 4'd3, 1, 4'h0);
        step();
        drive(1, 32'hB, 4'd3, 1, 4'h0);
        step();
        in_valid = 1'b0;
        fwd_rs = 4'd3;
        #1;
        chk("fwd_hit", 64'(fwd_hit), 1);
        chk("fwd_data", 64'(fwd_data), 64'hB);
        fwd_rs = 4'd4;
        #1;
        chk("fwd_miss", 64'(fwd_hit), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fwd_rs = 4'd3;
        #1;
        chk("fwd_flushed", 64'(fwd_hit), 0);
        drive(1, 32'hC, 4'd3, 0, 4'h0);
        step();
        drive(1, 32'hD, 4'd3, 0, 4'h0);
        step();
        in_valid = 1'b0;
        #1;
        chk("fwd_wb0", 64'(fwd_hit), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
`endif
        out_ready = 1'b0;
        drive(1, 32'h71, 4'd7, 1, 4'h7);
        step();
        drive(1, 32'h72, 4'd7, 1, 4'h7);
        step();
        in_valid = 1'b0;
        chk("mid_pre_occ", 64'(occ), 2);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_occ", 64'(occ), 0);
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_data", 64'(out_data), 0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_occ", 64'(occ), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
